relu_grad_gate: RTL and testbench

Backward-pass companion to the forward ReLU in the fully connected datapath. It records the forward ReLU pass/block decision for every neuron of one layer vector. It then gates the matching gradient stream with that recorded mask: a gradient passes where the forward ReLU passed, and is zeroed where it was blocked. It sits between the FC layer output and the gradient return path.

---
 rtl/relu_pkg.sv | 13 +
 rtl/relu_grad_out_reg.sv | 35 +++
 rtl/relu_grad_gate.sv | 103 ++++++++++
 tb/tb_relu_grad_gate.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_pkg.sv
// relu_pkg: shared types and sizing helpers for the ReLU gradient gate.
package relu_pkg;

    typedef enum logic [1:0] {CAPTURE, HOLD, APPLY} state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 64;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/relu_grad_out_reg.sv
// relu_grad_out_reg: single-stage valid/ready output register carrying data and last.
module relu_grad_out_reg
    import relu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/relu_grad_gate.sv
// relu_grad_gate: records the forward ReLU pass mask of one layer vector and
// gates the returning gradient stream with it.
module relu_grad_gate
    import relu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fwd_valid,
    input  logic [WIDTH-1:0]           fwd_data,
    input  logic                       fwd_last,
    output logic                       fwd_ready,
    input  logic                       grad_in_valid,
    input  logic [WIDTH-1:0]           grad_in_data,
    input  logic                       grad_in_last,
    output logic                       grad_in_ready,
    output logic                       grad_out_valid,
    output logic [WIDTH-1:0]           grad_out_data,
    output logic                       grad_out_last,
    input  logic                       grad_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] mask_count,
    output logic                       err,
    input  logic                       err_clr
);

    localparam int IW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    state_t           state, state_nxt;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic [DEPTH-1:0] mask;
    logic             reg_ready, fwd_hs, grad_hs, close, last_idx, term, err_set;
    logic [WIDTH-1:0] gated;

    assign fwd_hs   = fwd_valid && fwd_ready;
    assign grad_hs  = grad_in_valid && grad_in_ready;
    assign close    = fwd_hs && (fwd_last || wr_idx == IW'(DEPTH-1));
    assign last_idx = CW'(rd_idx) == mask_count - CW'(1);
    assign term     = grad_hs && (last_idx || grad_in_last);
    // Overflow on a forced close, or stream length disagreeing with the mask length.
    assign err_set  = (close && !fwd_last) || (grad_hs && (last_idx != grad_in_last));
    assign gated    = mask[rd_idx] ? grad_in_data : '0;

    always_comb begin
        state_nxt     = state;
        fwd_ready     = 1'b0;
        grad_in_ready = 1'b0;
        unique case (state)
            CAPTURE: begin
                fwd_ready = 1'b1;
                if (close) state_nxt = HOLD;
            end
            HOLD: state_nxt = APPLY;
            APPLY: begin
                grad_in_ready = reg_ready;
                if (term) state_nxt = CAPTURE;
            end
            default: state_nxt = CAPTURE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CAPTURE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            mask_count <= '0;
            mask       <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_set || (err && !err_clr);
            if (fwd_hs) begin
                mask[wr_idx] <= ~fwd_data[WIDTH-1];
                wr_idx       <= wr_idx + 1'b1;
                mask_count   <= mask_count + 1'b1;
            end
            if (term) begin
                wr_idx     <= '0;
                rd_idx     <= '0;
                mask_count <= '0;
            end else if (grad_hs) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    relu_grad_out_reg #(.WIDTH(WIDTH)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (grad_in_valid && state == APPLY),
        .in_data   (gated),
        .in_last   (last_idx || grad_in_last),
        .in_ready  (reg_ready),
        .out_valid (grad_out_valid),
        .out_data  (grad_out_data),
        .out_last  (grad_out_last),
        .out_ready (grad_out_ready)
    );

endmodule

// File: tb/tb_relu_grad_gate.sv
// tb_relu_grad_gate: randomized and directed checks of relu_grad_gate against a
// queue-based reference model of mask capture and gradient gating.
module tb_relu_grad_gate;
    import relu_pkg::*;

    localparam int W = 16;
    localparam int D = 64;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fwd_valid = 1'b0, fwd_last = 1'b0;
    logic [W-1:0] fwd_data = '0;
    logic         fwd_ready;
    logic         grad_in_valid = 1'b0, grad_in_last = 1'b0;
    logic [W-1:0] grad_in_data = '0;
    logic         grad_in_ready;
    logic         grad_out_valid, grad_out_last;
    logic [W-1:0] grad_out_data;
    logic         grad_out_ready = 1'b1;
    logic [$clog2(D+1)-1:0] mask_count;
    logic         err;
    logic         err_clr = 1'b0;

    int           pass_cnt = 0, total_cnt = 0;
    int           bp_mode = 0, bp_cyc = 0;
    beat_t        exp_q[$];
    bit           m_mask[$];
    bit           exp_err = 1'b0;
    logic [W-1:0] fwd_vals[$], grad_vals[$];
    beat_t        mon_e;
    logic         stall = 1'b0, st_l;
    logic [W-1:0] st_d;

    always #5 clk = ~clk;

    relu_grad_gate #(.WIDTH(W), .DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fwd_valid      (fwd_valid),
        .fwd_data       (fwd_data),
        .fwd_last       (fwd_last),
        .fwd_ready      (fwd_ready),
        .grad_in_valid  (grad_in_valid),
        .grad_in_data   (grad_in_data),
        .grad_in_last   (grad_in_last),
        .grad_in_ready  (grad_in_ready),
        .grad_out_valid (grad_out_valid),
        .grad_out_data  (grad_out_data),
        .grad_out_last  (grad_out_last),
        .grad_out_ready (grad_out_ready),
        .mask_count     (mask_count),
        .err            (err),
        .err_clr        (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Downstream ready: always high, random, or the repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        bp_cyc++;
        grad_out_ready = (bp_mode == 0) ? 1'b1 :
                         (bp_mode == 1) ? 1'($urandom_range(0, 1)) :
                         !((bp_cyc % 4 == 1) || (bp_cyc % 4 == 2));
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", grad_out_valid, 1);
                check("stall_data", grad_out_data, st_d);
                check("stall_last", grad_out_last, st_l);
            end
            if (grad_out_valid && grad_out_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("out_data", grad_out_data, mon_e.d);
                    check("out_last", grad_out_last, mon_e.l);
                end
            end
            stall = grad_out_valid && !grad_out_ready;
            st_d  = grad_out_data;
            st_l  = grad_out_last;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        fwd_valid = 0; fwd_last = 0; fwd_data = '0;
        grad_in_valid = 0; grad_in_last = 0; grad_in_data = '0; err_clr = 0;
        exp_q.delete();
        m_mask.delete();
        exp_err = 0;
        @(negedge clk);
        check("rst_fwd_ready", fwd_ready, 1);
        check("rst_grad_in_ready", grad_in_ready, 0);
        check("rst_out_valid", grad_out_valid, 0);
        check("rst_out_data", grad_out_data, 0);
        check("rst_out_last", grad_out_last, 0);
        check("rst_mask_count", mask_count, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic fwd_beat(input logic [W-1:0] d, input logic l);
        fwd_valid = 1; fwd_data = d; fwd_last = l;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (fwd_ready) break;
            if (t == 50) begin
                check("fwd_ready_timeout", fwd_ready, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic grad_beat(input logic [W-1:0] d, input logic l);
        grad_in_valid = 1; grad_in_data = d; grad_in_last = l;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (grad_in_ready) break;
            if (t == 50) begin
                check("grad_ready_timeout", grad_in_ready, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Sends fwd_vals; the model closes on last or on the DEPTH-th beat.
    task automatic capture(input bit with_last);
        int  n;
        bit  closed, l;
        n = fwd_vals.size();
        closed = 0;
        m_mask.delete();
        for (int i = 0; i < n && !closed; i++) begin
            l = with_last && (i == n - 1);
            m_mask.push_back($signed(fwd_vals[i]) >= 0);
            closed = l || (i == D - 1);
            if (closed && !l) exp_err = 1;
            fwd_beat(fwd_vals[i], l);
        end
        fwd_valid = 0; fwd_last = 0;
        @(negedge clk);
        check("hold_fwd_ready", fwd_ready, 0);
        check("hold_grad_ready", grad_in_ready, 0);
        check("mask_count", mask_count, m_mask.size());
        check("err_after_capture", err, exp_err);
        @(negedge clk);
        check("apply_grad_ready", grad_in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic apply(input int ng, input int glast_at, input bit clr_on_term);
        logic [W-1:0] g;
        bit    gl, li, tm;
        beat_t b;
        for (int k = 0; k < ng; k++) begin
            g  = (grad_vals.size() > k) ? grad_vals[k] : W'($urandom);
            gl = (k == glast_at);
            li = (k == m_mask.size() - 1);
            tm = gl || li;
            b.d = m_mask[k] ? g : '0;
            b.l = tm;
            exp_q.push_back(b);
            exp_err = (li != gl) ? 1'b1 : (tm && clr_on_term) ? 1'b0 : exp_err;
            err_clr = tm && clr_on_term;
            grad_beat(g, gl);
            err_clr = 0;
            if (tm) break;
        end
        grad_in_valid = 0; grad_in_last = 0;
    endtask

    task automatic finish_vec();
        for (int t = 0; t < 300 && (exp_q.size() != 0 || grad_out_valid); t++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        check("err", err, exp_err);
        check("back_to_capture", fwd_ready, 1);
        check("count_cleared", mask_count, 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        exp_err = 0;
        @(negedge clk);
        check("err_clr_alone", err, 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_fwd(input int n);
        fwd_vals.delete();
        for (int i = 0; i < n; i++) fwd_vals.push_back(W'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        fwd_vals = '{16'd5, 16'hFFFD, 16'd0, 16'h8000};
        capture(1);
        grad_vals = '{16'd100, 16'd200, 16'd300, 16'd400};
        apply(4, 3, 0);
        finish_vec();

        fwd_vals.delete();
        grad_vals.delete();
        for (int i = 0; i < D; i++) begin
            fwd_vals.push_back(16'd1);
            grad_vals.push_back(16'd7);
        end
        capture(0);
        apply(D, D - 1, 0);
        finish_vec();
        pulse_clr();

        grad_vals.delete();
        rand_fwd(3);
        capture(1);
        apply(3, 1, 0);
        finish_vec();
        pulse_clr();

        bp_mode = 2;
        rand_fwd(4);
        capture(1);
        apply(4, 3, 0);
        finish_vec();
        bp_mode = 0;

        rand_fwd(4);
        capture(1);
        apply(2, 3, 0);
        do_reset();
        rand_fwd(2);
        capture(1);
        apply(2, 1, 0);
        finish_vec();

        rand_fwd(3);
        capture(1);
        apply(3, 0, 1);
        finish_vec();
        pulse_clr();

        for (int r = 0; r < 25; r++) begin
            int n;
            bp_mode = $urandom_range(0, 1);
            n = $urandom_range(1, 8);
            rand_fwd(n);
            capture(1);
            apply(n, $urandom_range(0, n), 0);
            finish_vec();
            if (exp_err) pulse_clr();
        end
        bp_mode = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
